// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//
// Upstream controller for a 4:1 mux. Walks the enabled input channels in
// ascending order, holds each select value for a programmable settle time,
// samples the mux output, and assembles the samples into a 4-bit frame that is
// announced with a one-cycle frame_valid_o pulse. Supports one-shot and
// continuous scanning; a stop request always lets the current frame finish.
//
// Parameters
//   DWELL          settle cycles per channel before capture (>= 1)
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        request to begin a scan, honoured only while idle
//   stop_i         finish the current frame, then return to idle
//   cont_i         read at the end of a frame: 1 = scan again, 0 = go idle
//   ch_en_i[3:0]   channel enable mask, latched when a start is accepted
//   mux_out_i      output of the downstream 4:1 mux
//   s1_o, s0_o     mux select lines (MSB, LSB)
//   busy_o         high whenever a scan is in progress
//   frame_o[3:0]   last completed frame, bit i = sample of input i (0 if disabled)
//   frame_valid_o  one-cycle pulse when a new frame is presented
//   start_err_o    one-cycle pulse when start arrives with an empty mask
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       cont_i,
  input  logic [3:0] ch_en_i,
  input  logic       mux_out_i,
  output logic       s1_o,
  output logic       s0_o,
  output logic       busy_o,
  output logic [3:0] frame_o,
  output logic       frame_valid_o,
  output logic       start_err_o
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e        state_q;
  logic [1:0]    sel_q;
  logic [3:0]    en_q;
  logic [3:0]    sample_q;
  logic [3:0]    frame_q;
  logic [CW-1:0] cnt_q;
  logic          stop_pend_q;
  logic          busy_q;
  logic          frame_valid_q;
  logic          start_err_q;

  logic [3:0]    capture_d;
  logic          has_next_d;
  logic [1:0]    next_sel_d;

  // Lowest enabled channel of a mask; only called with a non-zero mask.
  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Sample vector including the bit being captured this cycle, and the next
  // enabled channel strictly above the current select (if any).
  always_comb begin
    capture_d        = sample_q;
    capture_d[sel_q] = mux_out_i;
    has_next_d       = 1'b0;
    next_sel_d       = sel_q;
    case (sel_q)
      2'd0: begin
        if (en_q[1]) begin
          has_next_d = 1'b1;
          next_sel_d = 2'd1;
        end else if (en_q[2]) begin
          has_next_d = 1'b1;
          next_sel_d = 2'd2;
        end else if (en_q[3]) begin
          has_next_d = 1'b1;
          next_sel_d = 2'd3;
        end
      end
      2'd1: begin
        if (en_q[2]) begin
          has_next_d = 1'b1;
          next_sel_d = 2'd2;
        end else if (en_q[3]) begin
          has_next_d = 1'b1;
          next_sel_d = 2'd3;
        end
      end
      2'd2: begin
        if (en_q[3]) begin
          has_next_d = 1'b1;
          next_sel_d = 2'd3;
        end
      end
      default: begin
        has_next_d = 1'b0;
      end
    endcase
  end

  // Scan FSM. Every output is a register so the mux select and status lines
  // are glitch-free. The select only moves on entry to SETTLE, so it is held
  // for the DWELL settle cycles plus the capture cycle before sampling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      sel_q         <= 2'd0;
      en_q          <= 4'd0;
      sample_q      <= 4'd0;
      frame_q       <= 4'd0;
      cnt_q         <= '0;
      stop_pend_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      start_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      start_err_q   <= 1'b0;

      // A stop seen while busy is remembered until the frame ends.
      if (busy_q && stop_i) begin
        stop_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          sel_q <= 2'd0;
          // stop together with start cancels the start entirely.
          if (start_i && !stop_i) begin
            if (ch_en_i != 4'd0) begin
              en_q     <= ch_en_i;
              sel_q    <= lowest_bit(ch_en_i);
              cnt_q    <= '0;
              sample_q <= 4'd0;
              busy_q   <= 1'b1;
              state_q  <= SETTLE;
            end else begin
              start_err_q <= 1'b1;
            end
          end
        end

        SETTLE: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= CAPTURE;
          end
        end

        CAPTURE: begin
          sample_q <= capture_d;
          if (has_next_d) begin
            sel_q   <= next_sel_d;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end else begin
            // Frame includes the capture happening on this same edge.
            frame_q       <= capture_d;
            frame_valid_q <= 1'b1;
            state_q       <= DONE;
          end
        end

        DONE: begin
          if (cont_i && !stop_pend_q) begin
            sel_q    <= lowest_bit(en_q);
            cnt_q    <= '0;
            sample_q <= 4'd0;
            state_q  <= SETTLE;
          end else begin
            stop_pend_q <= 1'b0;
            sel_q       <= 2'd0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s1_o          = sel_q[1];
  assign s0_o          = sel_q[0];
  assign busy_o        = busy_q;
  assign frame_o       = frame_q;
  assign frame_valid_o = frame_valid_q;
  assign start_err_o   = start_err_q;

endmodule
